// File: rtl/game_pkg.sv
// Shared definitions for the game-level sequencer: state codes, BCD limits
// and the default frame timings.
package game_pkg;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_START   = 4'd1,
    S_PLAY    = 4'd2,
    S_RESPAWN = 4'd3,
    S_WAVE    = 4'd4,
    S_OVER    = 4'd5
  } state_e;

  localparam logic [15:0] BCD_MAX            = 16'h9999;
  localparam logic [3:0]  WAVE_MAX           = 4'd9;
  localparam int          LIVES_INIT_DEF     = 3;
  localparam logic [15:0] POINTS_DEF         = 16'h0010;
  localparam logic [7:0]  START_FRAMES_DEF   = 8'd60;
  localparam logic [7:0]  RESPAWN_FRAMES_DEF = 8'd90;
  localparam logic [7:0]  WAVE_FRAMES_DEF    = 8'd120;
  localparam logic [7:0]  OVER_FRAMES_DEF    = 8'd180;

  // Frame counter never wraps so long waits cannot alias back to short ones.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/game_flow_ctrl_if.sv
// Event inputs and status outputs of the game sequencer, bundled as one bus.
// The master side produces events and observes status; the slave is the sequencer.
interface game_flow_ctrl_if;

  logic        frame_tick;
  logic        shoot;
  logic        alien_hit;
  logic        player_hit;
  logic        wave_clear;
  logic        game_over;
  logic [3:0]  game_status;
  logic        play_en;
  logic        field_rst;
  logic [15:0] score;
  logic [15:0] hi_score;
  logic [1:0]  lives;
  logic [3:0]  wave;

  modport master (
    output frame_tick, shoot, alien_hit, player_hit, wave_clear, game_over,
    input  game_status, play_en, field_rst, score, hi_score, lives, wave
  );

  modport slave (
    input  frame_tick, shoot, alien_hit, player_hit, wave_clear, game_over,
    output game_status, play_en, field_rst, score, hi_score, lives, wave
  );

endinterface

// File: rtl/bcd_add4.sv
// Combinational 4-digit packed-BCD adder; cout flags a sum beyond 9999
// so the caller can saturate.
module bcd_add4 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] sum,
  output logic        cout
);

  logic       carry;
  logic [4:0] digit;

  // Ripple digit by digit; a raw digit above 9 is corrected by +6 and carries.
  always_comb begin
    carry = 1'b0;
    digit = '0;
    sum   = '0;
    for (int i = 0; i < 4; i++) begin
      digit = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]} + {4'b0000, carry};
      if (digit > 5'd9) begin
        digit = digit + 5'd6;
        carry = 1'b1;
      end else begin
        carry = 1'b0;
      end
      sum[4*i +: 4] = digit[3:0];
    end
    cout = carry;
  end

endmodule

// File: rtl/game_flow_ctrl.sv
// Game-level sequencer: walks IDLE/START/PLAY/RESPAWN/WAVE/OVER, keeps the
// BCD score, high score, lives and wave count, and gates play and field reset.
module game_flow_ctrl
  import game_pkg::*;
#(
  parameter int          LIVES_INIT     = LIVES_INIT_DEF,
  parameter logic [15:0] POINTS         = POINTS_DEF,
  parameter logic [7:0]  START_FRAMES   = START_FRAMES_DEF,
  parameter logic [7:0]  RESPAWN_FRAMES = RESPAWN_FRAMES_DEF,
  parameter logic [7:0]  WAVE_FRAMES    = WAVE_FRAMES_DEF,
  parameter logic [7:0]  OVER_FRAMES    = OVER_FRAMES_DEF
) (
  input  logic             clk_100MHz,
  input  logic             reset,
  game_flow_ctrl_if.slave  bus
);

  state_e      state_q, state_d;
  logic [7:0]  frame_cnt_q, frame_cnt_d;
  logic        shoot_q;
  logic        shoot_re;
  logic [15:0] score_q, score_d;
  logic [15:0] hi_score_q, hi_score_d;
  logic [1:0]  lives_q, lives_d;
  logic [3:0]  wave_q, wave_d;
  logic        play_en_q, play_en_d;
  logic        field_rst_q, field_rst_d;
  logic [15:0] bcd_sum;
  logic        bcd_cout;
  logic [15:0] score_inc;

  bcd_add4 u_bcd_add4 (
    .a    (score_q),
    .b    (POINTS),
    .sum  (bcd_sum),
    .cout (bcd_cout)
  );

  assign score_inc = bcd_cout ? BCD_MAX : bcd_sum;
  assign shoot_re  = bus.shoot & ~shoot_q;

  always_comb begin
    state_d     = state_q;
    score_d     = score_q;
    hi_score_d  = hi_score_q;
    lives_d     = lives_q;
    wave_d      = wave_q;
    frame_cnt_d = frame_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (shoot_re) begin
          state_d = S_START;
          score_d = '0;
          lives_d = 2'(LIVES_INIT);
          wave_d  = 4'd1;
        end
      end
      S_START: begin
        if (bus.frame_tick && frame_cnt_q == START_FRAMES - 8'd1) state_d = S_PLAY;
      end
      // A hit on the same cycle as an exit event still scores.
      S_PLAY: begin
        if (bus.alien_hit) score_d = score_inc;
        if (bus.game_over) begin
          state_d = S_OVER;
        end else if (bus.player_hit) begin
          if (lives_q <= 2'd1) begin
            lives_d = 2'd0;
            state_d = S_OVER;
          end else begin
            lives_d = lives_q - 2'd1;
            state_d = S_RESPAWN;
          end
        end else if (bus.wave_clear) begin
          state_d = S_WAVE;
          wave_d  = (wave_q >= WAVE_MAX) ? WAVE_MAX : wave_q + 4'd1;
        end
      end
      S_RESPAWN: begin
        if (bus.frame_tick && frame_cnt_q == RESPAWN_FRAMES - 8'd1) state_d = S_PLAY;
      end
      S_WAVE: begin
        if (bus.frame_tick && frame_cnt_q == WAVE_FRAMES - 8'd1) state_d = S_PLAY;
      end
      S_OVER: begin
        if (shoot_re && frame_cnt_q >= OVER_FRAMES) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Packed BCD orders the same as binary, so a plain compare suffices.
    if (state_d == S_OVER && state_q != S_OVER && score_d > hi_score_q)
      hi_score_d = score_d;

    if (state_d != state_q)    frame_cnt_d = '0;
    else if (bus.frame_tick)   frame_cnt_d = sat_inc8(frame_cnt_q);

    play_en_d   = (state_d == S_PLAY);
    field_rst_d = (state_d == S_START) || (state_d == S_WAVE);
  end

  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      frame_cnt_q <= '0;
      shoot_q     <= 1'b0;
      score_q     <= '0;
      hi_score_q  <= '0;
      lives_q     <= '0;
      wave_q      <= '0;
      play_en_q   <= 1'b0;
      field_rst_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
      shoot_q     <= bus.shoot;
      score_q     <= score_d;
      hi_score_q  <= hi_score_d;
      lives_q     <= lives_d;
      wave_q      <= wave_d;
      play_en_q   <= play_en_d;
      field_rst_q <= field_rst_d;
    end
  end

  assign bus.game_status = state_q;
  assign bus.play_en     = play_en_q;
  assign bus.field_rst   = field_rst_q;
  assign bus.score       = score_q;
  assign bus.hi_score    = hi_score_q;
  assign bus.lives       = lives_q;
  assign bus.wave        = wave_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Scoreboard bench for game_flow_ctrl: directed stimulus queues expected
// status snapshots; a negedge monitor pops and compares them.
module tb_game_flow_ctrl;
  import game_pkg::*;

  localparam logic [4:0] EV_NONE   = 5'b00000;
  localparam logic [4:0] EV_TICK   = 5'b00001;
  localparam logic [4:0] EV_ALIEN  = 5'b00010;
  localparam logic [4:0] EV_PLAYER = 5'b00100;
  localparam logic [4:0] EV_CLEAR  = 5'b01000;
  localparam logic [4:0] EV_OVER   = 5'b10000;

  typedef struct {
    string       name;
    logic [3:0]  st;
    logic        pe;
    logic        fr;
    logic [15:0] sc;
    logic [15:0] hi;
    logic [1:0]  lv;
    logic [3:0]  wv;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  int   hits = 0;
  exp_t exp_q[$];

  game_flow_ctrl_if gif();

  game_flow_ctrl dut (
    .clk_100MHz (clk),
    .reset      (reset),
    .bus        (gif)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic [4:0] ev);
    gif.frame_tick = ev[0];
    gif.alien_hit  = ev[1];
    gif.player_hit = ev[2];
    gif.wave_clear = ev[3];
    gif.game_over  = ev[4];
    @(posedge clk);
    #1;
    gif.frame_tick = 1'b0;
    gif.alien_hit  = 1'b0;
    gif.player_hit = 1'b0;
    gif.wave_clear = 1'b0;
    gif.game_over  = 1'b0;
  endtask

  task automatic setShoot(input logic v);
    gif.shoot = v;
    @(posedge clk);
    #1;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      applyStimulus(EV_TICK);
      applyStimulus(EV_NONE);
    end
  endtask

  task automatic hitUntil(input int target);
    while (hits < target) begin
      applyStimulus(EV_ALIEN);
      hits++;
    end
  endtask

  task automatic checkOutput(input string name, input logic [3:0] st, input logic pe,
                             input logic fr, input logic [15:0] sc, input logic [15:0] hi,
                             input logic [1:0] lv, input logic [3:0] wv);
    exp_t e;
    e.name = name; e.st = st; e.pe = pe; e.fr = fr;
    e.sc = sc; e.hi = hi; e.lv = lv; e.wv = wv;
    exp_q.push_back(e);
  endtask

  task automatic compareField(input string name, input string field,
                              input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s.%s got=%h expected=%h", name, field, got, want);
    end
  endtask

  // Monitor: one queued snapshot is compared per falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      compareField(e.name, "status",    16'(gif.game_status), 16'(e.st));
      compareField(e.name, "play_en",   16'(gif.play_en),     16'(e.pe));
      compareField(e.name, "field_rst", 16'(gif.field_rst),   16'(e.fr));
      compareField(e.name, "score",     gif.score,            e.sc);
      compareField(e.name, "hi_score",  gif.hi_score,         e.hi);
      compareField(e.name, "lives",     16'(gif.lives),       16'(e.lv));
      compareField(e.name, "wave",      16'(gif.wave),        16'(e.wv));
    end
  end

  initial begin
    #2_000_000;
    errors++;
    $display("[TB] FAIL watchdog got=timeout expected=finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [3:0] w;
    reset = 1'b0;
    gif.shoot = 1'b0;
    gif.frame_tick = 1'b0; gif.alien_hit = 1'b0; gif.player_hit = 1'b0;
    gif.wave_clear = 1'b0; gif.game_over = 1'b0;

    @(posedge clk); #1;
    checkOutput("reset", S_IDLE, 1'b0, 1'b0, 16'h0000, 16'h0000, 2'd0, 4'd0);
    @(posedge clk); #1;
    reset = 1'b1;

    // Game 1: start, score, respawn, waves, saturation, priority, OVER lockout.
    repeat (10) applyStimulus(EV_NONE);
    checkOutput("idle_hold", S_IDLE, 1'b0, 1'b0, 16'h0000, 16'h0000, 2'd0, 4'd0);
    applyStimulus(EV_TICK | EV_ALIEN | EV_PLAYER | EV_CLEAR | EV_OVER);
    checkOutput("idle_ignore", S_IDLE, 1'b0, 1'b0, 16'h0000, 16'h0000, 2'd0, 4'd0);
    setShoot(1'b1);
    checkOutput("start", S_START, 1'b0, 1'b1, 16'h0000, 16'h0000, 2'd3, 4'd1);
    setShoot(1'b0);
    applyStimulus(EV_ALIEN | EV_PLAYER | EV_CLEAR | EV_OVER);
    checkOutput("start_ignore", S_START, 1'b0, 1'b1, 16'h0000, 16'h0000, 2'd3, 4'd1);
    for (int k = 1; k < 60; k++) begin
      tick(1);
      checkOutput("start_frame", S_START, 1'b0, 1'b1, 16'h0000, 16'h0000, 2'd3, 4'd1);
    end
    tick(1);
    checkOutput("play_entry", S_PLAY, 1'b1, 1'b0, 16'h0000, 16'h0000, 2'd3, 4'd1);

    applyStimulus(EV_ALIEN);
    checkOutput("hit1", S_PLAY, 1'b1, 1'b0, 16'h0010, 16'h0000, 2'd3, 4'd1);
    applyStimulus(EV_ALIEN);
    checkOutput("hit2", S_PLAY, 1'b1, 1'b0, 16'h0020, 16'h0000, 2'd3, 4'd1);
    applyStimulus(EV_ALIEN);
    checkOutput("hit3", S_PLAY, 1'b1, 1'b0, 16'h0030, 16'h0000, 2'd3, 4'd1);
    hits = 3;

    applyStimulus(EV_PLAYER);
    checkOutput("respawn", S_RESPAWN, 1'b0, 1'b0, 16'h0030, 16'h0000, 2'd2, 4'd1);
    applyStimulus(EV_ALIEN | EV_OVER);
    checkOutput("respawn_ignore", S_RESPAWN, 1'b0, 1'b0, 16'h0030, 16'h0000, 2'd2, 4'd1);
    tick(89);
    checkOutput("respawn_89", S_RESPAWN, 1'b0, 1'b0, 16'h0030, 16'h0000, 2'd2, 4'd1);
    tick(1);
    checkOutput("respawn_90", S_PLAY, 1'b1, 1'b0, 16'h0030, 16'h0000, 2'd2, 4'd1);

    w = 4'd1;
    for (int i = 1; i <= 9; i++) begin
      applyStimulus(EV_CLEAR);
      w = (w == 4'd9) ? 4'd9 : w + 4'd1;
      checkOutput("wave_entry", S_WAVE, 1'b0, 1'b1, 16'h0030, 16'h0000, 2'd2, w);
      tick(119);
      checkOutput("wave_119", S_WAVE, 1'b0, 1'b1, 16'h0030, 16'h0000, 2'd2, w);
      tick(1);
      checkOutput("wave_120", S_PLAY, 1'b1, 1'b0, 16'h0030, 16'h0000, 2'd2, w);
    end

    hitUntil(10);
    checkOutput("score_0100", S_PLAY, 1'b1, 1'b0, 16'h0100, 16'h0000, 2'd2, 4'd9);
    hitUntil(100);
    checkOutput("score_1000", S_PLAY, 1'b1, 1'b0, 16'h1000, 16'h0000, 2'd2, 4'd9);
    hitUntil(999);
    checkOutput("score_9990", S_PLAY, 1'b1, 1'b0, 16'h9990, 16'h0000, 2'd2, 4'd9);
    hitUntil(1000);
    checkOutput("score_sat", S_PLAY, 1'b1, 1'b0, 16'h9999, 16'h0000, 2'd2, 4'd9);
    hitUntil(1001);
    checkOutput("score_sat_hold", S_PLAY, 1'b1, 1'b0, 16'h9999, 16'h0000, 2'd2, 4'd9);

    applyStimulus(EV_OVER | EV_CLEAR);
    checkOutput("over_priority", S_OVER, 1'b0, 1'b0, 16'h9999, 16'h9999, 2'd2, 4'd9);
    applyStimulus(EV_ALIEN | EV_PLAYER);
    checkOutput("over_ignore", S_OVER, 1'b0, 1'b0, 16'h9999, 16'h9999, 2'd2, 4'd9);
    tick(100);
    setShoot(1'b1);
    checkOutput("over_lock_100", S_OVER, 1'b0, 1'b0, 16'h9999, 16'h9999, 2'd2, 4'd9);
    setShoot(1'b0);
    tick(81);
    setShoot(1'b1);
    checkOutput("over_exit_181", S_IDLE, 1'b0, 1'b0, 16'h9999, 16'h9999, 2'd2, 4'd9);
    setShoot(1'b0);

    // Game 2: run lives down to one, then a simultaneous hit and death.
    setShoot(1'b1);
    checkOutput("start2", S_START, 1'b0, 1'b1, 16'h0000, 16'h9999, 2'd3, 4'd1);
    setShoot(1'b0);
    tick(60);
    checkOutput("play2", S_PLAY, 1'b1, 1'b0, 16'h0000, 16'h9999, 2'd3, 4'd1);
    applyStimulus(EV_PLAYER);
    checkOutput("g2_respawn_a", S_RESPAWN, 1'b0, 1'b0, 16'h0000, 16'h9999, 2'd2, 4'd1);
    tick(90);
    applyStimulus(EV_PLAYER);
    checkOutput("g2_respawn_b", S_RESPAWN, 1'b0, 1'b0, 16'h0000, 16'h9999, 2'd1, 4'd1);
    tick(90);
    checkOutput("g2_play_last", S_PLAY, 1'b1, 1'b0, 16'h0000, 16'h9999, 2'd1, 4'd1);
    applyStimulus(EV_ALIEN | EV_PLAYER);
    checkOutput("g2_simul", S_OVER, 1'b0, 1'b0, 16'h0010, 16'h9999, 2'd0, 4'd1);
    tick(179);
    setShoot(1'b1);
    checkOutput("g2_lock_179", S_OVER, 1'b0, 1'b0, 16'h0010, 16'h9999, 2'd0, 4'd1);
    setShoot(1'b0);
    tick(1);
    setShoot(1'b1);
    checkOutput("g2_exit_180", S_IDLE, 1'b0, 1'b0, 16'h0010, 16'h9999, 2'd0, 4'd1);
    setShoot(1'b0);

    // Game 3: asynchronous reset in the middle of play.
    setShoot(1'b1);
    setShoot(1'b0);
    tick(60);
    applyStimulus(EV_ALIEN);
    checkOutput("g3_play", S_PLAY, 1'b1, 1'b0, 16'h0010, 16'h9999, 2'd3, 4'd1);
    @(posedge clk); #2;
    reset = 1'b0;
    checkOutput("async_reset", S_IDLE, 1'b0, 1'b0, 16'h0000, 16'h0000, 2'd0, 4'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    applyStimulus(EV_NONE);
    checkOutput("post_reset", S_IDLE, 1'b0, 1'b0, 16'h0000, 16'h0000, 2'd0, 4'd0);

    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain got=%0d expected=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
